// File: rtl/register_file_sb_if.sv
// rtl/register_file_sb_if.sv - read/write/reserve bus of the scoreboarded register file
interface register_file_sb_if #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int RPORTS = 2
);
  localparam int AW = $clog2(NREGS);

  logic [RPORTS*AW-1:0]   rdNum;
  logic [RPORTS*XLEN-1:0] rdData;
  logic [RPORTS-1:0]      rdBusy;
  logic                   wEn;
  logic [AW-1:0]          wNum;
  logic [XLEN-1:0]        wData;
  logic                   rsvEn;
  logic [AW-1:0]          rsvNum;
  logic                   flush;
  logic [NREGS-1:0]       busyVec;
  logic                   sbErr;

  modport master (
    output rdNum, wEn, wNum, wData, rsvEn, rsvNum, flush,
    input  rdData, rdBusy, busyVec, sbErr
  );

  modport slave (
    input  rdNum, wEn, wNum, wData, rsvEn, rsvNum, flush,
    output rdData, rdBusy, busyVec, sbErr
  );
endinterface

// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - multi-read-port register file with per-register busy scoreboard
module register_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 16,
  parameter int RPORTS = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  register_file_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]        regs_q [NREGS];
  logic [NREGS-1:0]       busy_q, busy_d;
  logic                   sb_err_q, sb_err_d;
  logic                   run_q;
  logic                   we, rsv;
  logic [AW-1:0]          rd_idx;
  logic [RPORTS*XLEN-1:0] rd_data;
  logic [RPORTS-1:0]      rd_busy;

  // run_q holds off updates on the first edge after reset release
  assign we  = run_q && bus.wEn   && (bus.wNum   != '0);
  assign rsv = run_q && bus.rsvEn && (bus.rsvNum != '0);

  always_comb begin
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    if (run_q && bus.flush) begin
      busy_d = '0;
    end
    if (we) begin
      busy_d[bus.wNum] = 1'b0;
    end
    if (rsv) begin
      if (busy_q[bus.rsvNum] && !(we && (bus.wNum == bus.rsvNum))) begin
        sb_err_d = 1'b1;
      end
      busy_d[bus.rsvNum] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q    <= 1'b0;
      busy_q   <= '0;
      sb_err_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      run_q    <= 1'b1;
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
      if (we) begin
        regs_q[bus.wNum] <= bus.wData;
      end
    end
  end

  // Bypass only forwards writes that will actually land on this edge
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_idx  = '0;
    for (int p = 0; p < RPORTS; p++) begin
      rd_idx = bus.rdNum[p*AW +: AW];
      rd_data[p*XLEN +: XLEN] = regs_q[rd_idx];
      rd_busy[p]              = busy_q[rd_idx];
      if ((BYPASS != 0) && we && (bus.wNum == rd_idx)) begin
        rd_data[p*XLEN +: XLEN] = bus.wData;
        rd_busy[p]              = 1'b0;
      end
      if (!reset || (rd_idx == '0)) begin
        rd_data[p*XLEN +: XLEN] = '0;
        rd_busy[p]              = 1'b0;
      end
    end
  end

  assign bus.rdData  = rd_data;
  assign bus.rdBusy  = rd_busy;
  assign bus.busyVec = busy_q;
  assign bus.sbErr   = sb_err_q;
endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - self-checking bench for register_file_sb, bypass and non-bypass builds
module tb_register_file_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rd_num = '0;
  logic        w_en = 1'b0;
  logic [3:0]  w_num = '0;
  logic [31:0] w_data = '0;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_num = '0;
  logic        flush = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  register_file_sb_if #(.XLEN(32), .NREGS(16), .RPORTS(2)) if_b ();
  register_file_sb_if #(.XLEN(32), .NREGS(16), .RPORTS(2)) if_n ();

  assign if_b.rdNum = rd_num;  assign if_n.rdNum = rd_num;
  assign if_b.wEn = w_en;      assign if_n.wEn = w_en;
  assign if_b.wNum = w_num;    assign if_n.wNum = w_num;
  assign if_b.wData = w_data;  assign if_n.wData = w_data;
  assign if_b.rsvEn = rsv_en;  assign if_n.rsvEn = rsv_en;
  assign if_b.rsvNum = rsv_num; assign if_n.rsvNum = rsv_num;
  assign if_b.flush = flush;   assign if_n.flush = flush;

  register_file_sb #(.XLEN(32), .NREGS(16), .RPORTS(2), .BYPASS(1)) dut_b (
    .clk(clk), .reset(rst_n), .bus(if_b.slave));
  register_file_sb #(.XLEN(32), .NREGS(16), .RPORTS(2), .BYPASS(0)) dut_n (
    .clk(clk), .reset(rst_n), .bus(if_n.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference state: the architectural view of registers, pending flags and the sticky error
  logic [31:0] m_reg [16] = '{default: 32'h0};
  bit   [15:0] m_busy = '0;
  bit          m_err = 1'b0;
  bit          m_run = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_reg[i]) m_reg[i] = 32'h0;
      m_busy = '0;
      m_err  = 1'b0;
      m_run  = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      bit [15:0] nb;
      for (int r = 1; r < 16; r++) begin
        bit wr_r, rv_r;
        wr_r = w_en && (w_num == r);
        rv_r = rsv_en && (rsv_num == r);
        nb[r] = flush ? 1'b0 : m_busy[r];
        if (wr_r) nb[r] = 1'b0;
        if (rv_r) begin
          nb[r] = 1'b1;
          if (m_busy[r] && !wr_r) m_err = 1'b1;
        end
        if (wr_r) m_reg[r] = w_data;
      end
      nb[0] = 1'b0;
      m_busy = nb;
    end
  end

  function automatic void exp_rd(input bit byp, input int p, output logic [31:0] d, output logic b);
    int idx;
    idx = int'(rd_num[p*4 +: 4]);
    d = m_reg[idx];
    b = m_busy[idx];
    if (byp && m_run && w_en && (int'(w_num) == idx)) begin
      d = w_data;
      b = 1'b0;
    end
    if (!rst_n || idx == 0) begin
      d = 32'h0;
      b = 1'b0;
    end
  endfunction

  always @(negedge clk) begin
    logic [31:0] d;
    logic b;
    for (int p = 0; p < 2; p++) begin
      exp_rd(1'b1, p, d, b);
      check($sformatf("byp_rdData%0d", p), 64'(if_b.rdData[p*32 +: 32]), 64'(d));
      check($sformatf("byp_rdBusy%0d", p), 64'(if_b.rdBusy[p]), 64'(b));
      exp_rd(1'b0, p, d, b);
      check($sformatf("nob_rdData%0d", p), 64'(if_n.rdData[p*32 +: 32]), 64'(d));
      check($sformatf("nob_rdBusy%0d", p), 64'(if_n.rdBusy[p]), 64'(b));
    end
    check("byp_busyVec", 64'(if_b.busyVec), 64'(m_busy));
    check("nob_busyVec", 64'(if_n.busyVec), 64'(m_busy));
    check("byp_sbErr", 64'(if_b.sbErr), 64'(m_err));
    check("nob_sbErr", 64'(if_n.sbErr), 64'(m_err));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check("rst_busyVec", 64'(if_b.busyVec), 64'h0);
    check("rst_sbErr", 64'(if_n.sbErr), 64'h0);
    rst_n = 1'b1;
    // Write issued on the release edge must be dropped
    w_en = 1'b1; w_num = 4'd1; w_data = 32'hAAAA; rd_num = {4'd1, 4'd1};
    step();
    idle();
    #1 check("release_write_dropped", 64'(if_b.rdData[31:0]), 64'h0);

    for (int r = 0; r < 16; r++) begin
      rd_num = {4'(r), 4'(r)};
      #1;
      check("init_rd0", 64'(if_b.rdData[31:0]), 64'h0);
      check("init_rd1", 64'(if_n.rdData[63:32]), 64'h0);
    end

    // Same-cycle forwarding versus next-cycle visibility
    step();
    w_en = 1'b1; w_num = 4'd5; w_data = 32'hDEADBEEF; rd_num = {4'd5, 4'd5};
    #1;
    check("bypass_same_cycle", 64'(if_b.rdData[31:0]), 64'hDEADBEEF);
    check("nobypass_same_cycle", 64'(if_n.rdData[31:0]), 64'h0);
    step();
    idle();
    #1 check("nobypass_next_cycle", 64'(if_n.rdData[63:32]), 64'hDEADBEEF);

    w_en = 1'b1; w_num = 4'd0; w_data = 32'h1234; rd_num = {4'd0, 4'd0};
    step();
    idle();
    rsv_en = 1'b1; rsv_num = 4'd0;
    step();
    idle();
    #1;
    check("reg0_read", 64'(if_n.rdData[31:0]), 64'h0);
    check("rsv0_busyVec", 64'(if_b.busyVec), 64'h0);

    rsv_en = 1'b1; rsv_num = 4'd3;
    step();
    idle();
    rd_num = {4'd5, 4'd3};
    #1;
    check("rsv3_busyVec", 64'(if_b.busyVec), 64'h0008);
    check("rsv3_rdBusy", 64'(if_n.rdBusy[0]), 64'h1);
    w_en = 1'b1; w_num = 4'd3; w_data = 32'h55;
    #1 check("bypass_clears_rdBusy", 64'(if_b.rdBusy[0]), 64'h0);
    step();
    idle();
    #1;
    check("wr3_busyVec", 64'(if_b.busyVec), 64'h0);
    check("wr3_data", 64'(if_n.rdData[31:0]), 64'h55);
    w_en = 1'b1; w_num = 4'd3; w_data = 32'h66; rsv_en = 1'b1; rsv_num = 4'd3;
    step();
    idle();
    #1;
    check("wr_rsv3_busyVec", 64'(if_b.busyVec), 64'h0008);
    check("wr_rsv3_sbErr", 64'(if_b.sbErr), 64'h0);
    check("wr_rsv3_data", 64'(if_n.rdData[31:0]), 64'h66);

    rsv_en = 1'b1; rsv_num = 4'd7;
    step();
    step();
    idle();
    #1 check("double_rsv_sbErr", 64'(if_b.sbErr), 64'h1);
    flush = 1'b1;
    step();
    idle();
    #1;
    check("flush_keeps_sbErr", 64'(if_n.sbErr), 64'h1);
    check("flush_busyVec", 64'(if_n.busyVec), 64'h0);

    rsv_en = 1'b1; rsv_num = 4'd2;
    step();
    rsv_num = 4'd4;
    step();
    idle();
    #1 check("busy_2_4", 64'(if_b.busyVec), 64'h0014);
    flush = 1'b1; rsv_en = 1'b1; rsv_num = 4'd9;
    step();
    idle();
    #1 check("flush_rsv9", 64'(if_b.busyVec), 64'h0200);
    flush = 1'b1; w_en = 1'b1; w_num = 4'd9; w_data = 32'hCAFE0009;
    step();
    idle();
    rd_num = {4'd9, 4'd5};
    #1;
    check("flush_wr9_busyVec", 64'(if_b.busyVec), 64'h0);
    check("flush_wr9_data", 64'(if_n.rdData[63:32]), 64'hCAFE0009);

    // Write/reserve burst interrupted by reset between edges
    for (int i = 1; i < 6; i++) begin
      w_en = 1'b1; w_num = 4'(i + 9); w_data = 32'h1000_0000 + 32'(i);
      rsv_en = 1'b1; rsv_num = 4'(i);
      step();
    end
    rd_num = {4'd11, 4'd10};
    #1 check("burst_data", 64'(if_n.rdData[31:0]), 64'h1000_0001);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_rd0", 64'(if_b.rdData[31:0]), 64'h0);
    check("midrst_rd1", 64'(if_n.rdData[63:32]), 64'h0);
    check("midrst_busyVec", 64'(if_b.busyVec), 64'h0);
    check("midrst_sbErr", 64'(if_n.sbErr), 64'h0);
    idle();
    step();
    rst_n = 1'b1;
    step();
    rd_num = {4'd5, 4'd9};
    #1 check("post_rst_data", 64'(if_n.rdData[31:0]), 64'h0);
    w_en = 1'b1; w_num = 4'd9; w_data = 32'h9999;
    step();
    idle();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
